adder_driver: RTL and testbench
===============================

# adder_driver

Requester-side sequencer for the self-timed `adder_32` completion protocol. It accepts operand pairs on a valid/ready stream, presents them to the adder, pulses the start strobe `F`, waits for the ready strobe `R`, and returns the captured sum, carry and measured latency on a valid/ready result stream. A watchdog forces completion if `R` never arrives.

## Interface
- `WIDTH`, 32: operand and sum width.
- `TIMEOUT`, 20: maximum WAIT cycles before forced capture; legal range 2..31.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  driver accepts operands.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_cin`  in  1  carry-in.
- `F`  out  1  start strobe to the adder and timer.
- `a`, `b`  out  WIDTH  registered operands to the adder.
- `cin`  out  1  registered carry-in to the adder.
- `R`  in  1  adder ready (completion) strobe.
- `sum`  in  WIDTH  adder sum.
- `cout`  in  1  adder carry-out.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `out_sum`  out  WIDTH  captured sum.
- `out_cout`  out  1  captured carry-out.
- `out_cycles`  out  5  WAIT cycles consumed, including the capture cycle.
- `out_timeout`  out  1  result was forced by the watchdog; `R` was not seen.

## Operation
- FSM states: IDLE, START, WAIT, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, register `in_a`/`in_b`/`in_cin` into `a`/`b`/`cin` and go to START.
- START:
  - `F`=1 for exactly this one cycle.
  - Clear the wait counter `cnt` to 0 and go to WAIT.
- WAIT:
  - `F`=0.
  - When `cnt`=0, ignore `R`, because it can be stale from the previous operation.
  - When `cnt`>=1 and `R`=1, capture `sum`/`cout` into `out_sum`/`out_cout`, set `out_cycles`=`cnt`+1, clear `out_timeout`, and go to HOLD.
  - Otherwise, if `cnt`=`TIMEOUT`-1, capture `sum`/`cout` anyway, set `out_cycles`=`TIMEOUT` and `out_timeout`=1, and go to HOLD.
  - Otherwise, increment `cnt`.
  - `R` wins over timeout when both hold in the same cycle.
- HOLD:
  - `out_valid`=1 and all `out_*` stay stable.
  - On `out_ready`=1, go to IDLE. `out_*` retain their values after that.
- `a`/`b`/`cin` change only on an accept. They stay stable through START, WAIT and HOLD.
- `in_ready` is 0 in START, WAIT and HOLD. There is no operand skid buffer, so at most one operation is in flight.
- Back-to-back operation: the HOLD→IDLE transition and the next accept need separate cycles. Never accept in HOLD.

## Timing
- Reset (asynchronous, effective immediately):
  - State goes to IDLE.
  - `F`, `a`, `b`, `cin`, `out_valid`, `out_sum`, `out_cout`, `out_cycles`, `out_timeout` and `cnt` go to 0.
  - `in_ready`=0 while `reset` is high and 1 in the first cycle after release.
- Reset mid-operation aborts the operation: `F` drops and the pending result is discarded without `out_valid`.
- Cycle numbering, with accept at edge 0:
  - Cycle 1 is START with `F`=1.
  - Cycle 2 is the first WAIT (`R` ignored).
  - The earliest capture is at the end of cycle 3.
  - `out_valid`=1 from cycle 4.
- Minimum `out_cycles` is 2.
- Minimum turnaround from accept to the next accept is 5 cycles, with `out_ready` held at 1.
- Timeout: `out_valid` rises `TIMEOUT`+2 cycles after accept.
- All outputs are registered or decoded from state. `in_ready`/`out_valid` have no combinational path from `in_valid`/`out_ready`.

## Test plan
- **Basic add.** Input: `in_a`=0x0000_0005, `in_b`=0x0000_0003, `cin`=0; model `R` rising 4 cycles after `F`. Required: `out_sum`=0x8, `out_cout`=0, `out_cycles`=4, `out_timeout`=0, and `F` high for exactly one cycle.
- **Full-carry operands.** Input: `in_a`=0xFFFF_FFFF, `in_b`=0x0000_0001, `cin`=0; `R` held at 1 throughout. Required: stale `R` ignored in the first WAIT cycle, capture in the second, `out_sum`=0, `out_cout`=1, `out_cycles`=2.
- **Watchdog.** `R` tied to 0, `TIMEOUT`=20. Required: `out_valid` rises 22 cycles after accept, with `out_timeout`=1 and `out_cycles`=20.
- **Backpressure.** `out_ready`=0 for 10 cycles in HOLD. Required: `out_*` stable, `in_ready`=0, and `a`/`b` unchanged. Raising `out_ready` leads to IDLE on the next cycle.
- **Mid-WAIT reset.** Assert `reset` in the third WAIT cycle. Required: every output is 0 immediately with no `out_valid`. After release, the next operand pair completes normally.
- **Stream of 8 random pairs.** Random `in_valid`/`out_ready` gaps. Required: results arrive in order and match `in_a`+`in_b`+`in_cin` modulo 2^32 with the correct `out_cout`.

Source files
------------

// File: rtl/adder_driver.sv
// Requester-side sequencer for the self-timed adder_32 completion protocol:
// accept operands, strobe F, wait for R (or watchdog), hold the result for the consumer.
module adder_driver #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             F,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic             R,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [4:0]       out_cycles,
    output logic             out_timeout
);

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

    state_t     state;
    state_t     state_next;
    logic [4:0] cnt;
    logic       accept;
    logic       hit;
    logic       expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // R is ignored while cnt is 0 because it may still be high from the previous operation.
    always_comb begin
        accept     = (state == IDLE) && in_valid;
        hit        = (state == WAIT) && (cnt != '0) && R;
        expire     = (state == WAIT) && !hit && (cnt == 5'(TIMEOUT - 1));
        in_ready   = (state == IDLE) && !reset;
        F          = (state == START);
        out_valid  = (state == HOLD);
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (hit || expire) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a           <= '0;
            b           <= '0;
            cin         <= 1'b0;
            cnt         <= '0;
            out_sum     <= '0;
            out_cout    <= 1'b0;
            out_cycles  <= '0;
            out_timeout <= 1'b0;
        end else begin
            if (accept) begin
                a   <= in_a;
                b   <= in_b;
                cin <= in_cin;
            end
            if (state == START) begin
                cnt <= '0;
            end else if (state == WAIT && !hit && !expire) begin
                cnt <= cnt + 5'd1;
            end
            if (hit) begin
                out_sum     <= sum;
                out_cout    <= cout;
                out_cycles  <= cnt + 5'd1;
                out_timeout <= 1'b0;
            end else if (expire) begin
                out_sum     <= sum;
                out_cout    <= cout;
                out_cycles  <= 5'(TIMEOUT);
                out_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_driver.sv
// Directed self-checking bench for adder_driver with a behavioural adder_32 stand-in.
module tb_adder_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        F;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        r;
    logic [31:0] m_sum;
    logic        m_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic [4:0]  out_cycles;
    logic        out_timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign {m_cout, m_sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

    adder_driver #(.WIDTH(32), .TIMEOUT(20)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .F(F), .a(a), .b(b), .cin(cin),
        .R(r), .sum(m_sum), .cout(m_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_cycles(out_cycles), .out_timeout(out_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers an operand pair and returns in cycle 1 (START) after the accepting edge.
    task automatic accept(input logic [31:0] x, input logic [31:0] y, input logic c);
        int n = 0;
        in_a = x; in_b = y; in_cin = c; in_valid = 1'b1;
        while (!in_ready && n < 50) begin step(); n++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_wait in_ready=%0b required=1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; r = 0; out_ready = 0;
        step(); step();
        checks++;
        if ({F, a, b, cin, out_valid, out_sum, out_cout, out_cycles, out_timeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs F=%0b a=%h b=%h out_valid=%0b out_sum=%h required all 0",
                     F, a, b, out_valid, out_sum);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b required=0", in_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b required=1", in_ready); end
    endtask

    task automatic test_basic_add();
        int fcount = 0;
        r = 0;
        accept(32'h5, 32'h3, 1'b0);
        checks++;
        if (a !== 32'h5 || b !== 32'h3 || cin !== 1'b0) begin
            failures++; $display("FAIL basic_operands a=%h b=%h cin=%0b required 5/3/0", a, b, cin);
        end
        for (int n = 1; n <= 5; n++) begin
            if (F === 1'b1) fcount++;
            if (n == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b required=0", out_valid); end
                r = 1'b1;
            end
            step();
        end
        checks++;
        if (fcount != 1) begin failures++; $display("FAIL basic_f_pulse cycles_high=%0d required=1", fcount); end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h8 || out_cout !== 1'b0 || out_cycles !== 5'd4 || out_timeout !== 1'b0) begin
            failures++;
            $display("FAIL basic_result valid=%0b sum=%h cout=%0b cycles=%0d timeout=%0b required 1/8/0/4/0",
                     out_valid, out_sum, out_cout, out_cycles, out_timeout);
        end
        r = 0; out_ready = 1; step(); out_ready = 0;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_return_idle in_ready=%0b required=1", in_ready); end
    endtask

    task automatic test_full_carry();
        r = 1'b1;
        accept(32'hFFFF_FFFF, 32'h1, 1'b0);
        step(); step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL carry_stale_r out_valid=%0b required=0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h0 || out_cout !== 1'b1 || out_cycles !== 5'd2 || out_timeout !== 1'b0) begin
            failures++;
            $display("FAIL carry_result valid=%0b sum=%h cout=%0b cycles=%0d timeout=%0b required 1/0/1/2/0",
                     out_valid, out_sum, out_cout, out_cycles, out_timeout);
        end
        r = 0; out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_watchdog();
        int n = 1;
        r = 0;
        accept(32'h1234_5678, 32'h1111_1111, 1'b1);
        while (!out_valid && n < 40) begin step(); n++; end
        checks++;
        if (n != 22) begin failures++; $display("FAIL watchdog_latency cycles=%0d required=22", n); end
        checks++;
        if (out_timeout !== 1'b1 || out_cycles !== 5'd20 || out_sum !== 32'h2345_678A) begin
            failures++;
            $display("FAIL watchdog_result timeout=%0b cycles=%0d sum=%h required 1/20/2345678a",
                     out_timeout, out_cycles, out_sum);
        end
    endtask

    // Continues from the watchdog result still held in HOLD.
    task automatic test_backpressure();
        in_valid = 1'b1; in_a = 32'hCAFE_F00D; in_b = 32'h0BAD_BEEF; in_cin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h2345_678A || out_cycles !== 5'd20
                || out_timeout !== 1'b1 || a !== 32'h1234_5678 || b !== 32'h1111_1111) begin
                failures++;
                $display("FAIL hold_stable i=%0d valid=%0b in_ready=%0b sum=%h a=%h b=%h required 1/0/2345678a/12345678/11111111",
                         i, out_valid, in_ready, out_sum, a, b);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL hold_release valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_sum !== 32'h2345_678A || out_timeout !== 1'b1 || a !== 32'h1234_5678) begin
            failures++; $display("FAIL idle_retain sum=%h timeout=%0b a=%h required 2345678a/1/12345678",
                                 out_sum, out_timeout, a);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_mid_wait_reset();
        r = 0;
        accept(32'h7, 32'h9, 1'b0);
        step(); step(); step();
        reset = 1'b1;
        #1;
        checks++;
        if ({F, a, b, cin, out_valid, out_sum, out_cout, out_cycles, out_timeout, in_ready} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs F=%0b a=%h b=%h valid=%0b sum=%h cycles=%0d timeout=%0b in_ready=%0b required all 0",
                     F, a, b, out_valid, out_sum, out_cycles, out_timeout, in_ready);
        end
        step(); step();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_release valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        r = 1'b1;
        accept(32'h100, 32'h200, 1'b1);
        step(); step(); step();
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h301 || out_cout !== 1'b0 || out_cycles !== 5'd2) begin
            failures++;
            $display("FAIL midreset_next valid=%0b sum=%h cout=%0b cycles=%0d required 1/301/0/2",
                     out_valid, out_sum, out_cout, out_cycles);
        end
        r = 0; out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_back_to_back();
        r = 1'b1; out_ready = 1'b1;
        accept(32'hFF, 32'h1, 1'b1);
        in_valid = 1'b1;
        for (int n = 2; n <= 6; n++) begin
            step();
            checks++;
            if (F !== (n == 6) || in_ready !== (n == 5) || out_valid !== (n == 4)) begin
                failures++;
                $display("FAIL b2b_cycle n=%0d F=%0b in_ready=%0b valid=%0b required %0b/%0b/%0b",
                         n, F, in_ready, out_valid, n == 6, n == 5, n == 4);
            end
        end
        in_valid = 1'b0;
        step(); step(); step(); step();
        checks++;
        if (in_ready !== 1'b1 || out_sum !== 32'h101 || out_cycles !== 5'd2) begin
            failures++; $display("FAIL b2b_second in_ready=%0b sum=%h cycles=%0d required 1/101/2",
                                 in_ready, out_sum, out_cycles);
        end
        r = 0; out_ready = 0;
    endtask

    task automatic test_stream();
        logic [31:0] sa [8] = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                                32'hDEAD_BEEF, 32'hF000_0000, 32'h7FFF_FFFF, 32'hAAAA_AAAA};
        logic [31:0] sb [8] = '{32'h2, 32'h8000_0000, 32'h0, 32'h8765_4321,
                                32'h1, 32'h2000_0000, 32'h1, 32'h5555_5555};
        logic        sc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] es [8] = '{32'h3, 32'h0, 32'h0, 32'h9999_9999,
                                32'hDEAD_BEF1, 32'h1000_0001, 32'h8000_0000, 32'h0};
        logic        ec [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            int gap = $urandom_range(0, 3);
            int dly = $urandom_range(0, 5);
            int hold = $urandom_range(0, 3);
            repeat (gap) step();
            accept(sa[i], sb[i], sc[i]);
            repeat (dly) step();
            r = 1'b1;
            while (!out_valid && n < 30) begin step(); n++; end
            repeat (hold) step();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== es[i] || out_cout !== ec[i] || out_timeout !== 1'b0) begin
                failures++;
                $display("FAIL stream_%0d valid=%0b sum=%h cout=%0b timeout=%0b required 1/%h/%0b/0",
                         i, out_valid, out_sum, out_cout, out_timeout, es[i], ec[i]);
            end
            r = 1'b0; out_ready = 1'b1; step(); out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_full_carry();
        test_watchdog();
        test_backpressure();
        test_mid_wait_reset();
        test_back_to_back();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
